// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: function codes, stage FSM states,
// and the condition-code register layout with its reset value.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_MUL = 3'd4
  } alu_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_BUSY = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: sign-magnitude shift-add over MUL_CYCLES cycles.
// done is held high (with result/ovf valid) until the cycle after it is seen.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int BPC = (WIDTH + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int CW  = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES);

  logic               run;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  // Magnitude of the most negative value still fits as an unsigned WIDTH word.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    for (int k = 0; k < BPC; k++) begin
      if (mplier_n[0]) acc_n = acc_n + mcand_n;
      mcand_n  = mcand_n << 1;
      mplier_n = mplier_n >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
    end else if (run) begin
      if (cnt != LAST) begin
        acc    <= acc_n;
        mcand  <= mcand_n;
        mplier <= mplier_n;
        cnt    <= cnt + 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done   = run && (cnt == LAST);
  assign prod   = neg ? (~acc + 1'b1) : acc;
  assign result = prod[WIDTH-1:0];
  // Fits in WIDTH signed bits only if the top WIDTH+1 bits are all equal.
  assign ovf    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

endmodule

// File: rtl/alu_cc_stage.sv
// Registered execute-stage ALU with valid/ready ports and the architectural
// CC register. Optional iterative multiply (fn 4) under ALU_MUL_EN.
module alu_cc_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  alu_state_e       state, state_n;
  logic             in_fire, out_fire, is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_err;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q, err_q, set_cc_q;
  cc_t              cc_q;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic             mul_ovf;

`ifdef ALU_MUL_EN
  assign is_mul = (in_fn == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (in_fire && is_mul),
    .a      (in_a),
    .b      (in_b),
    .done   (mul_done),
    .result (mul_res),
    .ovf    (mul_ovf)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_ovf  = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE) || ((state == ST_FULL) && out_ready);
  assign out_valid = (state == ST_FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (in_fn)
      ALU_ADD: begin
        alu_res = in_a + in_b;
        alu_ovf = (in_a[MSB] == in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = in_a - in_b;
        alu_ovf = (in_a[MSB] != in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      ALU_AND: alu_res = in_a & in_b;
      ALU_XOR: alu_res = in_a ^ in_b;
`ifdef ALU_MUL_EN
      ALU_MUL: alu_err = 1'b0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_fire) state_n = is_mul ? ST_BUSY : ST_FULL;
      ST_FULL: begin
        if (in_fire)       state_n = is_mul ? ST_BUSY : ST_FULL;
        else if (out_fire) state_n = ST_IDLE;
      end
      ST_BUSY: if (mul_done) state_n = ST_FULL;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      set_cc_q <= 1'b0;
    end else if (in_fire) begin
      res_q    <= is_mul ? '0 : alu_res;
      ovf_q    <= is_mul ? 1'b0 : alu_ovf;
      err_q    <= is_mul ? 1'b0 : alu_err;
      set_cc_q <= in_set_cc;
    end else if (mul_done) begin
      res_q <= mul_res;
      ovf_q <= mul_ovf;
      err_q <= 1'b0;
    end
  end

  // CC follows retirement, not acceptance, so a stalled result never leaks early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RST;
    end else if (out_fire && set_cc_q && !err_q) begin
      cc_q.zf <= (res_q == '0);
      cc_q.sf <= res_q[MSB];
      cc_q.of <= ovf_q;
    end
  end

  assign out_result = res_q;
  assign out_ovf    = ovf_q;
  assign out_err    = err_q;
  assign cc_zf      = cc_q.zf;
  assign cc_sf      = cc_q.sf;
  assign cc_of      = cc_q.of;

endmodule

// File: tb/tb_alu_cc_stage.sv
// Directed bench for alu_cc_stage (WIDTH=64); multiply cases compile in
// only when ALU_MUL_EN is defined.
module tb_alu_cc_stage;

  localparam int W  = 64;
  localparam int MC = W;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_set_cc;
  logic [2:0]   in_fn;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_ovf, out_err;
  logic [W-1:0] out_result;
  logic         cc_zf, cc_sf, cc_of;

  int n_cmp = 0;
  int n_bad = 0;

  alu_cc_stage #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fn      (in_fn),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_set_cc  (in_set_cc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_err    (out_err),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sc);
    in_valid  = 1'b1;
    in_fn     = fn;
    in_a      = a;
    in_b      = b;
    in_set_cc = sc;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
    chk(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, zf, sf, of});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fn     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    in_set_cc = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk_cc("rst_cc", 1'b1, 1'b0, 1'b0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd1);
    chk("rst_res", out_result, 64'd0);

    // ADD overflow with set_cc
    drive(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    step();
    in_valid = 1'b0;
    chk("add_ov", 64'(out_valid), 64'd1);
    chk("add_res", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_ovf", 64'(out_ovf), 64'd1);
    chk_cc("add_cc_pre", 1'b1, 1'b0, 1'b0);
    step();
    chk("add_ret", 64'(out_valid), 64'd0);
    chk_cc("add_cc", 1'b0, 1'b1, 1'b1);

    // SUB -1 - -5 (set_cc), then SUB 5-5 (no set_cc), back to back
    drive(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    step();
    chk("sub1_res", out_result, 64'd4);
    chk("sub1_ovf", 64'(out_ovf), 64'd0);
    drive(3'd1, 64'd5, 64'd5, 1'b0);
    step();
    in_valid = 1'b0;
    chk("sub2_res", out_result, 64'd0);
    chk_cc("sub1_cc", 1'b0, 1'b0, 1'b0);
    step();
    chk("sub2_ret", 64'(out_valid), 64'd0);
    chk_cc("sub2_cc", 1'b0, 1'b0, 1'b0);

    // XOR then AND with out_ready 1,0,1
    drive(3'd3, 64'hF0F0, 64'hFF00, 1'b0);
    step();
    chk("xor_res", out_result, 64'h0FF0);
    drive(3'd2, 64'hF0F0, 64'hFF00, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("stall_ir0", 64'(in_ready), 64'd0);
    step();
    chk("stall_ov", 64'(out_valid), 64'd1);
    chk("stall_res", out_result, 64'h0FF0);
    chk("stall_ir1", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("and_res", out_result, 64'hF000);
    chk("and_ov", 64'(out_valid), 64'd1);
    step();
    chk("and_ret", 64'(out_valid), 64'd0);

    // illegal fn 5 with set_cc: CC must stay zf0 sf0 of0
    drive(3'd5, 64'd3, 64'd4, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ill_err", 64'(out_err), 64'd1);
    chk("ill_res", out_result, 64'd0);
    chk("ill_ovf", 64'(out_ovf), 64'd0);
    step();
    chk_cc("ill_cc", 1'b0, 1'b0, 1'b0);

`ifndef ALU_MUL_EN
    drive(3'd4, 64'd3, 64'd7, 1'b1);
    step();
    in_valid = 1'b0;
    chk("mul_off_err", 64'(out_err), 64'd1);
    chk("mul_off_res", out_result, 64'd0);
    step();
    chk_cc("mul_off_cc", 1'b0, 1'b0, 1'b0);
`else
    begin
      int n;
      // MUL -3 * 7, measure latency
      drive(3'd4, -64'sd3, 64'd7, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (n < 4 * MC) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        n++;
      end
      chk("mul_lat", 64'(n), 64'(MC + 1));
      chk("mul_res", out_result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mul_ovf", 64'(out_ovf), 64'd0);
      step();

      // 2^62 * 4 overflows
      drive(3'd4, 64'h4000_0000_0000_0000, 64'd4, 1'b0);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 4 * MC) begin
        step();
        n++;
      end
      chk("mul2_ov", 64'(out_valid), 64'd1);
      chk("mul2_res", out_result, 64'd0);
      chk("mul2_ovf", 64'(out_ovf), 64'd1);
      step();

      // reset pulse while BUSY
      drive(3'd4, 64'd2, 64'd3, 1'b1);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < MC + 5; i++) begin
        step();
        if (out_valid) n++;
      end
      chk("busy_rst_ov", 64'(n), 64'd0);
      chk_cc("busy_rst_cc", 1'b1, 1'b0, 1'b0);
      // move CC off reset value for the following check
      drive(3'd0, 64'd1, 64'd0, 1'b1);
      step();
      in_valid = 1'b0;
      step();
    end
`endif

    // reset while FULL and stalled: result discarded, CC back to reset
    drive(3'd0, 64'd1, 64'd1, 1'b1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("full_ov", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("full_rst_ov", 64'(out_valid), 64'd0);
    chk_cc("full_rst_cc", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_ov", 64'(out_valid), 64'd0);
    chk("post_rst_ir", 64'(in_ready), 64'd1);
    chk_cc("post_rst_cc", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
